// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the EX-stage RV32M unit.
// Holds the funct3 op encoding, FSM states and special-case results.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in EX.
// Ports: clk_i, reset_ni (async, active-low), start_i, funct3_i,
//   rs1_data_i, rs2_data_i, flush_i -> stall_o, done_o (1-cycle), result_o.
// Option: define MULDIV_FAST_MUL_EN for a single-cycle multiply path.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d, op_in;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              is_div, is_rem, a_sgn, b_sgn, ovf, stall_c;
    logic [XLEN-1:0]   ma, mb, diff;
    logic [XLEN:0]     tmp, sum;
    logic              ge;
    logic [2*XLEN-1:0] step;

    // The accumulator is {hi, lo}: product halves for multiply,
    // {partial remainder, dividend/quotient shift} for divide.
    function automatic logic [XLEN-1:0] sel_result(
        input muldiv_op_e        op,
        input logic              neg,
        input logic [2*XLEN-1:0] v
    );
        logic [2*XLEN-1:0] p;
        p = neg ? -v : v;
        case (op)
            OP_MUL:                      return p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return p[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:
                return neg ? -v[XLEN-1:0] : v[XLEN-1:0];
            default:
                return neg ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
        endcase
    endfunction

    always_comb begin
        op_in  = muldiv_op_e'(funct3_i);
        is_div = funct3_i[2];
        is_rem = funct3_i[2] & funct3_i[1];
        a_sgn  = rs1_data_i[XLEN-1] &
                 (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_sgn  = rs2_data_i[XLEN-1] &
                 (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        ma     = a_sgn ? -rs1_data_i : rs1_data_i;
        mb     = b_sgn ? -rs2_data_i : rs2_data_i;
        ovf    = (op_in inside {OP_DIV, OP_REM}) &&
                 rs1_data_i == INT_MIN && rs2_data_i == DIV0_QUOT;
    end

    // One radix-2 step: shift-add for multiply, restoring for divide.
    always_comb begin
        tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge   = tmp >= {1'b0, opnd_q};
        diff = tmp[XLEN-1:0] - opnd_q;
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, opnd_q} : '0);
        if (op_q[2]) begin
            step = {ge ? diff : tmp[XLEN-1:0], acc_q[XLEN-2:0], ge};
        end else begin
            step = {sum, acc_q[XLEN-1:1]};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] xa, xb, prod;
    always_comb begin
        xa   = {{XLEN{a_sgn}}, rs1_data_i};
        xb   = {{XLEN{b_sgn}}, rs2_data_i};
        prod = xa * xb;
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        res_d   = res_q;
        stall_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    stall_c = 1'b1;
                    op_d    = op_in;
                    cnt_d   = '0;
                    neg_d   = is_rem ? a_sgn : (a_sgn ^ b_sgn);
                    if (is_div && rs2_data_i == '0) begin
                        res_d   = is_rem ? rs1_data_i : DIV0_QUOT;
                        state_d = DONE;
                    end else if (ovf) begin
                        res_d   = is_rem ? '0 : INT_MIN;
                        state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div) begin
                        res_d   = sel_result(op_in, 1'b0, prod);
                        state_d = DONE;
`endif
                    end else begin
                        opnd_d  = is_div ? mb : ma;
                        acc_d   = {{XLEN{1'b0}}, is_div ? ma : mb};
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall_c = 1'b1;
                acc_d   = step;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    res_d   = sel_result(op_q, neg_q, step);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            stall_c = 1'b0;
        end
    end

    // Reset gates stall so upstream frees immediately, with no edge.
    assign stall_o  = stall_c & reset_ni;
    assign done_o   = (state_q == DONE) & ~flush_i;
    assign result_o = res_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

endmodule
